// File: rtl/hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_ctrl
// Description : Per-operand forwarding selects, load-use stall FSM with
//               configurable latency, memory-busy freeze and stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_forward_ctrl #(
    parameter int AW           = 5,
    parameter int NUM_SRC      = 2,
    parameter int LOAD_LATENCY = 1,
    parameter int CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SRC*AW-1:0]  id_src,
    input  logic [NUM_SRC-1:0]     id_src_used,
    input  logic [NUM_SRC*AW-1:0]  ex_src,
    input  logic [AW-1:0]          ex_rd,
    input  logic                   ex_regwrite,
    input  logic                   ex_memread,
    input  logic [AW-1:0]          mem_rd,
    input  logic                   mem_regwrite,
    input  logic [AW-1:0]          wb_rd,
    input  logic                   wb_regwrite,
    input  logic                   mem_busy,
    input  logic                   cnt_clr,
    output logic [2*NUM_SRC-1:0]   fwd_sel,
    output logic                   pc_we,
    output logic                   ifid_we,
    output logic                   idex_bubble,
    output logic                   freeze,
    output logic                   stall_active,
    output logic [CNT_W-1:0]       stall_cycles
);

    localparam int REM_W = $clog2(LOAD_LATENCY + 1);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    state_t           r_ret, w_ret_nxt;
    state_t           w_act;
    logic [REM_W-1:0] r_rem, w_rem_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_lu_match, w_lu;
    logic             w_pc_we, w_ifid_we, w_bubble, w_freeze;

    // Forwarding: EX/MEM wins over MEM/WB; register 0 never forwards
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        logic [AW-1:0] w_src;
        logic [1:0]    w_sel;
        assign w_src = ex_src[i*AW +: AW];
        always_comb begin
            w_sel = 2'b00;
            if (mem_regwrite && (mem_rd != '0) && (w_src == mem_rd))
                w_sel = 2'b10;
            else if (wb_regwrite && (wb_rd != '0) && (w_src == wb_rd))
                w_sel = 2'b01;
        end
        assign fwd_sel[2*i +: 2] = reset ? 2'b00 : w_sel;
    end

    always_comb begin
        w_lu_match = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_used[i] && (id_src[i*AW +: AW] == ex_rd))
                w_lu_match = 1'b1;
        end
        w_lu = ex_memread && ex_regwrite && (ex_rd != '0) && w_lu_match;
    end

    // MEM_WAIT behaves as its saved return state on the first non-busy cycle
    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret;
        w_rem_nxt   = r_rem;
        w_pc_we     = 1'b1;
        w_ifid_we   = 1'b1;
        w_bubble    = 1'b0;
        w_freeze    = 1'b0;
        w_act       = (r_state == MEM_WAIT) ? r_ret : r_state;
        if (mem_busy) begin
            w_freeze    = 1'b1;
            w_pc_we     = 1'b0;
            w_ifid_we   = 1'b0;
            w_state_nxt = MEM_WAIT;
            if (r_state != MEM_WAIT)
                w_ret_nxt = r_state;
        end else begin
            case (w_act)
                RUN: begin
                    w_state_nxt = RUN;
                    if (w_lu) begin
                        w_pc_we   = 1'b0;
                        w_ifid_we = 1'b0;
                        w_bubble  = 1'b1;
                        if (LOAD_LATENCY > 1) begin
                            w_state_nxt = LOAD_STALL;
                            w_rem_nxt   = REM_W'(LOAD_LATENCY - 1);
                        end
                    end
                end
                LOAD_STALL: begin
                    w_pc_we     = 1'b0;
                    w_ifid_we   = 1'b0;
                    w_bubble    = 1'b1;
                    w_rem_nxt   = r_rem - REM_W'(1);
                    w_state_nxt = (r_rem == REM_W'(1)) ? RUN : LOAD_STALL;
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
            r_ret   <= RUN;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ret   <= w_ret_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (cnt_clr)
            r_cnt <= '0;
        else if (!pc_we && (r_cnt != '1))
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign pc_we        = ~reset & w_pc_we;
    assign ifid_we      = ~reset & w_ifid_we;
    assign idex_bubble  = reset | w_bubble;
    assign freeze       = ~reset & w_freeze;
    assign stall_active = (r_state != RUN);
    assign stall_cycles = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_forward_ctrl
// Description : Scoreboard bench for hazard_forward_ctrl (LOAD_LATENCY=3, CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_ctrl;

    localparam int AW  = 5;
    localparam int NS  = 2;
    localparam int LL  = 3;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [NS*AW-1:0] id_src, ex_src;
    logic [NS-1:0]    id_src_used;
    logic [AW-1:0]    ex_rd, mem_rd, wb_rd;
    logic             ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;
    logic             mem_busy, cnt_clr;
    logic [2*NS-1:0]  fwd_sel;
    logic             pc_we, ifid_we, idex_bubble, freeze, stall_active;
    logic [CW-1:0]    stall_cycles;

    hazard_forward_ctrl #(.AW(AW), .NUM_SRC(NS), .LOAD_LATENCY(LL), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .id_src(id_src), .id_src_used(id_src_used),
        .ex_src(ex_src), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .mem_busy(mem_busy),
        .cnt_clr(cnt_clr), .fwd_sel(fwd_sel), .pc_we(pc_we), .ifid_we(ifid_we),
        .idex_bubble(idex_bubble), .freeze(freeze), .stall_active(stall_active),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] fwd;
        logic       pc_we, ifid_we, bubble, freeze, active;
        logic [3:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   passed = 0;
    int   total  = 0;

    // Reference model: stall cycles still owed, whether last cycle was busy
    int   owed      = 0;
    bit   prev_busy = 1'b0;
    int   count     = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic logic [1:0] ref_fwd(input logic [AW-1:0] s);
        if (mem_regwrite && mem_rd != 0 && s == mem_rd) return 2'd2;
        if (wb_regwrite && wb_rd != 0 && s == wb_rd) return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit ref_lu();
        bit hit = 1'b0;
        for (int i = 0; i < NS; i++)
            if (id_src_used[i] && id_src[i*AW +: AW] == ex_rd) hit = 1'b1;
        return ex_memread && ex_regwrite && ex_rd != 0 && hit;
    endfunction

    // Called at posedge+1 with inputs set; records this cycle's expectation
    task automatic step();
        exp_t e;
        e = '0;
        if (reset) begin
            e.bubble = 1'b1;
            owed = 0; prev_busy = 1'b0; count = 0;
        end else begin
            e.fwd    = {ref_fwd(ex_src[2*AW-1:AW]), ref_fwd(ex_src[AW-1:0])};
            e.active = prev_busy || (owed > 0);
            e.cnt    = 4'(count);
            if (mem_busy) begin
                e.freeze = 1'b1;
            end else if (owed > 0) begin
                e.bubble = 1'b1;
                owed--;
            end else if (ref_lu()) begin
                e.bubble = 1'b1;
                owed = LL - 1;
            end else begin
                e.pc_we = 1'b1; e.ifid_we = 1'b1;
            end
            prev_busy = mem_busy;
            if (cnt_clr) count = 0;
            else if (!e.pc_we && count < CMAX) count++;
        end
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        id_src = '0; id_src_used = '0; ex_src = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
        ex_regwrite = 0; ex_memread = 0; mem_regwrite = 0; wb_regwrite = 0;
        mem_busy = 0; cnt_clr = 0;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            check("fwd_sel",      fwd_sel,      m_e.fwd);
            check("pc_we",        pc_we,        m_e.pc_we);
            check("ifid_we",      ifid_we,      m_e.ifid_we);
            check("idex_bubble",  idex_bubble,  m_e.bubble);
            check("freeze",       freeze,       m_e.freeze);
            check("stall_active", stall_active, m_e.active);
            check("stall_cycles", stall_cycles, m_e.cnt);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        step(); step();
        reset = 1'b0;

        // Forwarding: rs from EX/MEM, rt from MEM/WB, then both to r9
        ex_src = {5'd9, 5'd8}; mem_rd = 5'd8; mem_regwrite = 1; wb_rd = 5'd9; wb_regwrite = 1;
        step();
        mem_rd = 5'd9;
        step();
        ex_src = {5'd0, 5'd3}; mem_rd = 5'd3; wb_rd = 5'd3;
        step();
        ex_src = {5'd0, 5'd0}; mem_rd = 5'd0; wb_rd = 5'd0;
        step();

        // Load-use with a 2-cycle memory stall in the middle
        idle_inputs(); cnt_clr = 1; step(); cnt_clr = 0;
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd5; id_src = {5'd0, 5'd5}; id_src_used = 2'b01;
        step();
        idle_inputs(); step();
        mem_busy = 1; step(); step();
        mem_busy = 0; step(); step(); step();

        // Unused operand never stalls
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd5; id_src = {5'd0, 5'd5}; id_src_used = 2'b10;
        step();

        // Counter saturation, then clear during a stall
        idle_inputs(); mem_busy = 1;
        repeat (20) step();
        cnt_clr = 1; step();
        cnt_clr = 0; mem_busy = 0; step(); step();

        // Asynchronous reset while in LOAD_STALL
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd7; id_src = {5'd7, 5'd0}; id_src_used = 2'b10;
        step();
        ex_memread = 0; ex_src = {5'd0, 5'd8}; mem_rd = 5'd8; mem_regwrite = 1;
        check("lstall_active", stall_active, 1);
        #2 reset = 1'b1;
        #1;
        check("rst_pc_we",   pc_we,        0);
        check("rst_ifid_we", ifid_we,      0);
        check("rst_bubble",  idex_bubble,  1);
        check("rst_freeze",  freeze,       0);
        check("rst_fwd",     fwd_sel,      0);
        check("rst_active",  stall_active, 0);
        check("rst_cnt",     stall_cycles, 0);
        @(posedge clk); #1;
        step();
        reset = 1'b0; idle_inputs();
        step(); step();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            id_src       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            ex_src       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            id_src_used  = 2'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 7));
            mem_rd       = 5'($urandom_range(0, 7));
            wb_rd        = 5'($urandom_range(0, 7));
            ex_regwrite  = ($urandom_range(0, 3) != 0);
            ex_memread   = ($urandom_range(0, 2) == 0);
            mem_regwrite = $urandom_range(0, 1);
            wb_regwrite  = $urandom_range(0, 1);
            mem_busy     = ($urandom_range(0, 5) == 0);
            cnt_clr      = ($urandom_range(0, 40) == 0);
            reset        = ($urandom_range(0, 200) == 0);
            step();
        end
        reset = 1'b0;

        repeat (3) @(negedge clk);
        check("queue_drain", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
Parametrised pipeline hazard controller for the 5-stage MIPS core. It replaces the purely combinational forwarding logic and adds three functions:
- independent per-operand forwarding selects for NUM_SRC operands;
- a load-use stall state machine with configurable load latency;
- a global freeze while data memory is busy, plus a saturating stall-cycle performance counter.

It sits beside the ID/EX pipeline registers. It drives the ALU operand muxes and the PC, IF/ID and ID/EX write enables.

Parameters:
AW, 5, register address width.
NUM_SRC, 2, number of source operands per instruction (operand 0 = rs, operand 1 = rt).
LOAD_LATENCY, 1, load-use stall length in cycles (>=1).
CNT_W, 16, stall counter width.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-high reset.
id_src  in  NUM_SRC*AW  source registers of the instruction in ID; operand i at [i*AW +: AW].
id_src_used  in  NUM_SRC  bit i set = ID instruction actually reads operand i.
ex_src  in  NUM_SRC*AW  source registers held in ID/EX.
ex_rd  in  AW  destination register of the instruction in EX.
ex_regwrite  in  1  EX instruction writes a register.
ex_memread  in  1  EX instruction is a load.
mem_rd  in  AW  EX/MEM destination register.
mem_regwrite  in  1  EX/MEM writes a register.
wb_rd  in  AW  MEM/WB destination register.
wb_regwrite  in  1  MEM/WB writes a register.
mem_busy  in  1  data memory not ready this cycle.
cnt_clr  in  1  synchronous clear of stall_cycles.
fwd_sel  out  2*NUM_SRC  operand i mux select at [2i+1:2i]: 00 regfile, 01 MEM/WB, 10 EX/MEM.
pc_we  out  1  PC write enable.
ifid_we  out  1  IF/ID write enable.
idex_bubble  out  1  load NOP into ID/EX this cycle.
freeze  out  1  hold every pipeline register (PC through MEM/WB).
stall_active  out  1  state != RUN.
stall_cycles  out  CNT_W  count of cycles with pc_we=0, saturating.

Behaviour:
- Forwarding is combinational and evaluated per operand independently. Each fwd_sel field is driven by exactly one decision.
  - 10 if mem_regwrite && mem_rd!=0 && ex_src[i]==mem_rd.
  - Otherwise 01 if wb_regwrite && wb_rd!=0 && ex_src[i]==wb_rd.
  - Otherwise 00. EX/MEM has priority over MEM/WB. Code 11 is never driven.
- Load-use hazard (lu) = ex_memread && ex_regwrite && ex_rd!=0 && some i with id_src_used[i] && id_src[i]==ex_rd.
- FSM states are RUN, LOAD_STALL and MEM_WAIT. There is a down-counter rem of width clog2(LOAD_LATENCY+1).
- RUN:
  - If mem_busy: freeze=1. Next state is MEM_WAIT with return target RUN.
  - Else if lu: pc_we=0, ifid_we=0, idex_bubble=1. If LOAD_LATENCY>1, next state is LOAD_STALL with rem=LOAD_LATENCY-1; otherwise stay in RUN.
  - Else all enables are 1 and bubble is 0.
- LOAD_STALL:
  - If mem_busy: freeze=1, rem held. Next state is MEM_WAIT with return target LOAD_STALL.
  - Else pc_we=0, ifid_we=0, idex_bubble=1, and rem decrements. Go to RUN when rem==1 this cycle.
- MEM_WAIT:
  - freeze=1, pc_we=0, ifid_we=0, idex_bubble=0.
  - On the first cycle with mem_busy=0, act as the saved return state in that same cycle. lu is re-evaluated if the return state is RUN.
- freeze=1 overrides idex_bubble (forced 0) and forces pc_we/ifid_we to 0.
- stall_active = (state != RUN) || (registered) mem_busy-entry. Precisely, it is 1 whenever the current state is LOAD_STALL or MEM_WAIT.
- stall_cycles increments on every clk edge where pc_we==0 and the count is not all-ones. It holds at 2^CNT_W-1.
  - cnt_clr takes priority: the count becomes 0 that edge, and the clear cycle is not counted.
- Reset (asynchronous, active-high):
  - State goes to RUN, rem=0, stall_cycles=0, immediately.
  - While reset is high: pc_we=0, ifid_we=0, idex_bubble=1, freeze=0, fwd_sel=0.
  - Reset during LOAD_STALL or MEM_WAIT abandons the stall. The first cycle after release is plain RUN.
- Register 0 never matches, for either forwarding or load-use.

Test Plan:
1. Forwarding: ex_src={rt=9,rs=8}, mem_rd=8 & mem_regwrite=1, wb_rd=9 & wb_regwrite=1 -> fwd_sel=4'b01_10. Then set mem_rd=9 -> fwd_sel=4'b10_00 (rs now 00).
2. Priority and zero: ex_src rs=3, mem_rd=wb_rd=3 with both regwrite -> rs select 10. Set ex_src rs=0 with mem_rd=0 -> 00.
3. Load-use, LOAD_LATENCY=1: ex_memread=1, ex_rd=5, id_src rs=5 used -> one cycle of pc_we=0, ifid_we=0, idex_bubble=1, stall_cycles +1. With id_src_used[0]=0 -> no stall.
4. Load-use, LOAD_LATENCY=3: lu pulse -> exactly 3 consecutive stall cycles, stall_active=1 for the last 2, then RUN. Insert mem_busy=1 for 2 cycles mid-stall -> freeze=1, bubble=0, total pc_we=0 cycles=5, stall_cycles=5.
5. Counter: CNT_W=4, 20 busy cycles -> stall_cycles saturates at 15. cnt_clr concurrent with a stall -> 0.
6. Reset in LOAD_STALL (async, between edges) -> outputs switch to reset values without a clock edge. After release: state RUN, stall_cycles=0, pc_we=1 with no hazard.
